// File: rtl/m3_gate_monitor.sv
// rtl/m3_gate_monitor.sv - gate-drive shoot-through/dead-time checker and six-step decoder
// Define M3MON_FAULT_LATCH_EN to make the fault flags sticky until clrFaultI.
module m3_gate_monitor #(
  parameter int DEAD_MIN = 4,
  parameter int PERIOD_W = 20
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                aHpI,
  input  logic                bHpI,
  input  logic                cHpI,
  input  logic                aLpI,
  input  logic                bLpI,
  input  logic                cLpI,
  input  logic                enI,
  input  logic                clrFaultI,
  output logic                faultO,
  output logic [2:0]          faultLegO,
  output logic                deadViolO,
  output logic [2:0]          stepO,
  output logic                stepValidO,
  output logic                dirO,
  output logic                seqErrO,
  output logic [PERIOD_W-1:0] periodO,
  output logic                periodValidO,
  output logic                stallO
);

  localparam int CNT_W = $clog2(DEAD_MIN + 1);
  localparam logic [CNT_W-1:0] DEAD_SAT = CNT_W'(DEAD_MIN);

  typedef enum logic [1:0] {LEG_OFF, LEG_HIGH, LEG_LOW, LEG_SHOOT} leg_t;

  logic [2:0]          r_hp, r_lp;
  leg_t                w_state [3];
  leg_t                r_last  [3];
  logic [CNT_W-1:0]    r_dead  [3];
  logic [2:0]          r_side_high;
  logic [2:0]          w_high, w_low, w_off, w_shoot, w_viol;
  logic [2:0]          r_fault_leg;
  logic                r_dead_viol;
  logic                w_pat_valid;
  logic [2:0]          w_pat_step, w_inc, w_dec;
  logic [2:0]          r_step;
  logic                r_step_valid, r_dir, r_seq_err;
  logic [PERIOD_W-1:0] r_per_cnt, r_period;
  logic                r_period_valid, r_have0;

  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      r_hp <= 3'b000;
      r_lp <= 3'b111;
    end else begin
      r_hp <= {cHpI, bHpI, aHpI};
      r_lp <= {cLpI, bLpI, aLpI};
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      case ({r_hp[i], r_lp[i]})
        2'b11:   w_state[i] = LEG_HIGH;
        2'b00:   w_state[i] = LEG_LOW;
        2'b01:   w_state[i] = LEG_OFF;
        default: w_state[i] = LEG_SHOOT;
      endcase
      w_high[i]  = (w_state[i] == LEG_HIGH);
      w_low[i]   = (w_state[i] == LEG_LOW);
      w_off[i]   = (w_state[i] == LEG_OFF);
      w_shoot[i] = (w_state[i] == LEG_SHOOT);
      // A direct swap between sides is treated as a zero-length OFF gap.
      w_viol[i] = 1'b0;
      if (w_low[i]) begin
        if (r_last[i] == LEG_HIGH) w_viol[i] = 1'b1;
        else if (r_last[i] == LEG_OFF && r_side_high[i] && r_dead[i] < DEAD_SAT) w_viol[i] = 1'b1;
      end else if (w_high[i]) begin
        if (r_last[i] == LEG_LOW) w_viol[i] = 1'b1;
        else if (r_last[i] == LEG_OFF && !r_side_high[i] && r_dead[i] < DEAD_SAT) w_viol[i] = 1'b1;
      end
    end
  end

  // r_dead holds the number of consecutive OFF cycles, so entry loads 1.
  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      for (int i = 0; i < 3; i++) begin
        r_last[i] <= LEG_OFF;
        r_dead[i] <= DEAD_SAT;
      end
      r_side_high <= 3'b111;
      r_dead_viol <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_last[i] <= w_state[i];
        if (w_off[i]) begin
          if (r_last[i] != LEG_OFF)    r_dead[i] <= CNT_W'(1);
          else if (r_dead[i] != DEAD_SAT) r_dead[i] <= r_dead[i] + 1'b1;
        end
        if (w_high[i])     r_side_high[i] <= 1'b1;
        else if (w_low[i]) r_side_high[i] <= 1'b0;
      end
      r_dead_viol <= |w_viol;
    end
  end

`ifdef M3MON_FAULT_LATCH_EN
  always_ff @(posedge clkI) begin
    if (!nRstI)         r_fault_leg <= 3'b000;
    else if (clrFaultI) r_fault_leg <= w_shoot;
    else                r_fault_leg <= r_fault_leg | w_shoot;
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = clrFaultI;
  always_ff @(posedge clkI) begin
    if (!nRstI) r_fault_leg <= 3'b000;
    else        r_fault_leg <= w_shoot;
  end
`endif

  always_comb begin
    w_pat_valid = 1'b1;
    case ({w_high, w_low})
      6'b001_010: w_pat_step = 3'd0;
      6'b001_100: w_pat_step = 3'd1;
      6'b010_100: w_pat_step = 3'd2;
      6'b010_001: w_pat_step = 3'd3;
      6'b100_001: w_pat_step = 3'd4;
      6'b100_010: w_pat_step = 3'd5;
      default: begin
        w_pat_step  = 3'd7;
        w_pat_valid = 1'b0;
      end
    endcase
    if ((w_high | w_low | w_off) != 3'b111) w_pat_valid = 1'b0;
    w_inc = (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
    w_dec = (r_step == 3'd0) ? 3'd5 : r_step - 3'd1;
  end

  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      r_step         <= 3'd7;
      r_dir          <= 1'b0;
      r_step_valid   <= 1'b0;
      r_seq_err      <= 1'b0;
      r_per_cnt      <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_have0        <= 1'b0;
    end else if (!enI) begin
      r_step         <= 3'd7;
      r_dir          <= 1'b0;
      r_step_valid   <= 1'b0;
      r_seq_err      <= 1'b0;
      r_per_cnt      <= '0;
      r_period_valid <= 1'b0;
      r_have0        <= 1'b0;
    end else begin
      r_step_valid   <= 1'b0;
      r_seq_err      <= 1'b0;
      r_period_valid <= 1'b0;
      if (r_per_cnt != '1) r_per_cnt <= r_per_cnt + 1'b1;
      if (w_pat_valid && w_pat_step != r_step) begin
        r_step       <= w_pat_step;
        r_step_valid <= 1'b1;
        if (r_step != 3'd7) begin
          if (w_pat_step == w_inc)      r_dir     <= 1'b1;
          else if (w_pat_step == w_dec) r_dir     <= 1'b0;
          else                          r_seq_err <= 1'b1;
        end
        if (w_pat_step == 3'd0) begin
          r_per_cnt <= PERIOD_W'(1);
          r_have0   <= 1'b1;
          if (r_have0) begin
            r_period       <= r_per_cnt;
            r_period_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign faultO       = |r_fault_leg;
  assign faultLegO    = r_fault_leg;
  assign deadViolO    = r_dead_viol;
  assign stepO        = r_step;
  assign stepValidO   = r_step_valid;
  assign dirO         = r_dir;
  assign seqErrO      = r_seq_err;
  assign periodO      = r_period;
  assign periodValidO = r_period_valid;
  assign stallO       = &r_per_cnt;

endmodule

// File: tb/tb_m3_gate_monitor.sv
// tb/tb_m3_gate_monitor.sv - directed bench for m3_gate_monitor
// Built with PERIOD_W = 12 so saturation is reachable in a short run.
module tb_m3_gate_monitor;

  localparam int PW = 12;

  logic          clkI = 1'b0;
  logic          nRstI = 1'b0;
  logic [2:0]    hp = 3'b000;
  logic [2:0]    lp = 3'b111;
  logic          enI = 1'b0;
  logic          clrFaultI = 1'b0;
  logic          faultO;
  logic [2:0]    faultLegO;
  logic          deadViolO;
  logic [2:0]    stepO;
  logic          stepValidO;
  logic          dirO;
  logic          seqErrO;
  logic [PW-1:0] periodO;
  logic          periodValidO;
  logic          stallO;

  int checks = 0;
  int failures = 0;
  int pv_count = 0;

  m3_gate_monitor #(.DEAD_MIN(4), .PERIOD_W(PW)) dut (
    .clkI(clkI), .nRstI(nRstI),
    .aHpI(hp[0]), .bHpI(hp[1]), .cHpI(hp[2]),
    .aLpI(lp[0]), .bLpI(lp[1]), .cLpI(lp[2]),
    .enI(enI), .clrFaultI(clrFaultI),
    .faultO(faultO), .faultLegO(faultLegO), .deadViolO(deadViolO),
    .stepO(stepO), .stepValidO(stepValidO), .dirO(dirO), .seqErrO(seqErrO),
    .periodO(periodO), .periodValidO(periodValidO), .stallO(stallO)
  );

  always #5 clkI = ~clkI;

  always @(negedge clkI) if (periodValidO === 1'b1) pv_count <= pv_count + 1;

  task automatic tick();
    @(posedge clkI);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_step(input int s);
    case (s)
      0: begin hp = 3'b001; lp = 3'b101; end
      1: begin hp = 3'b001; lp = 3'b011; end
      2: begin hp = 3'b010; lp = 3'b011; end
      3: begin hp = 3'b010; lp = 3'b110; end
      4: begin hp = 3'b100; lp = 3'b110; end
      default: begin hp = 3'b100; lp = 3'b101; end
    endcase
  endtask

  task automatic go_step(input int s);
    set_step(s);
    tick();
    tick();
  endtask

  task automatic set_b(input logic h, input logic l);
    hp[1] = h;
    lp[1] = l;
  endtask

  task automatic test_reset();
    nRstI = 1'b0; enI = 1'b0; hp = 3'b000; lp = 3'b111;
    wait_n(3);
    checks++; if (faultO !== 1'b0) begin failures++; $display("FAIL rst_fault got=%0b exp=0", faultO); end
    checks++; if (faultLegO !== 3'b000) begin failures++; $display("FAIL rst_fault_leg got=%0b exp=000", faultLegO); end
    checks++; if (deadViolO !== 1'b0) begin failures++; $display("FAIL rst_dead got=%0b exp=0", deadViolO); end
    checks++; if (stepO !== 3'd7) begin failures++; $display("FAIL rst_step got=%0d exp=7", stepO); end
    checks++; if ({stepValidO, dirO, seqErrO, periodValidO, stallO} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%0b exp=0", {stepValidO, dirO, seqErrO, periodValidO, stallO}); end
    checks++; if (periodO !== 12'd0) begin failures++; $display("FAIL rst_period got=%0d exp=0", periodO); end
    nRstI = 1'b1;
    tick();
    checks++; if (stepO !== 3'd7) begin failures++; $display("FAIL rst_step_after got=%0d exp=7", stepO); end
  endtask

  task automatic test_fault();
    logic [2:0] exp_leg;
    hp = 3'b001; lp = 3'b110;
    tick();
    checks++; if (faultO !== 1'b0) begin failures++; $display("FAIL fault_latency got=%0b exp=0", faultO); end
    hp = 3'b000; lp = 3'b111;
    tick();
    checks++; if (faultO !== 1'b1) begin failures++; $display("FAIL fault_set got=%0b exp=1", faultO); end
    checks++; if (faultLegO !== 3'b001) begin failures++; $display("FAIL fault_leg_a got=%0b exp=001", faultLegO); end
    tick();
`ifdef M3MON_FAULT_LATCH_EN
    exp_leg = 3'b001;
`else
    exp_leg = 3'b000;
`endif
    checks++; if (faultLegO !== exp_leg) begin failures++; $display("FAIL fault_hold got=%0b exp=%0b", faultLegO, exp_leg); end
    clrFaultI = 1'b1;
    tick();
    clrFaultI = 1'b0;
    checks++; if ({faultO, faultLegO} !== 4'b0) begin failures++; $display("FAIL fault_clear got=%0b exp=0", {faultO, faultLegO}); end
    hp = 3'b100; lp = 3'b011; clrFaultI = 1'b1;
    wait_n(2);
    checks++; if ({faultO, faultLegO} !== 4'b1100) begin failures++; $display("FAIL fault_set_wins got=%0b exp=1100", {faultO, faultLegO}); end
    tick();
    checks++; if ({faultO, faultLegO} !== 4'b1100) begin failures++; $display("FAIL fault_held got=%0b exp=1100", {faultO, faultLegO}); end
    hp = 3'b000; lp = 3'b111;
    wait_n(2);
    clrFaultI = 1'b0;
    checks++; if ({faultO, faultLegO} !== 4'b0) begin failures++; $display("FAIL fault_release got=%0b exp=0", {faultO, faultLegO}); end
  endtask

  task automatic test_deadtime();
    set_b(1, 1); wait_n(6);
    set_b(0, 1); wait_n(2);
    set_b(0, 0);
    tick();
    checks++; if (deadViolO !== 1'b0) begin failures++; $display("FAIL dead_off2_early got=%0b exp=0", deadViolO); end
    tick();
    checks++; if (deadViolO !== 1'b1) begin failures++; $display("FAIL dead_off2 got=%0b exp=1", deadViolO); end
    tick();
    checks++; if (deadViolO !== 1'b0) begin failures++; $display("FAIL dead_off2_width got=%0b exp=0", deadViolO); end
    set_b(1, 1); wait_n(6);
    set_b(0, 1); wait_n(4);
    set_b(0, 0);
    wait_n(2);
    checks++; if (deadViolO !== 1'b0) begin failures++; $display("FAIL dead_off4 got=%0b exp=0", deadViolO); end
    tick();
    checks++; if (deadViolO !== 1'b0) begin failures++; $display("FAIL dead_off4_late got=%0b exp=0", deadViolO); end
    wait_n(4);
    set_b(0, 1); wait_n(1);
    set_b(1, 1);
    wait_n(2);
    checks++; if (deadViolO !== 1'b1) begin failures++; $display("FAIL dead_low_high got=%0b exp=1", deadViolO); end
    wait_n(6);
    set_b(0, 1); wait_n(1);
    set_b(1, 1);
    wait_n(2);
    checks++; if (deadViolO !== 1'b0) begin failures++; $display("FAIL dead_chop got=%0b exp=0", deadViolO); end
    wait_n(4);
    set_b(0, 0);
    wait_n(2);
    checks++; if (deadViolO !== 1'b1) begin failures++; $display("FAIL dead_direct got=%0b exp=1", deadViolO); end
    tick();
    checks++; if (deadViolO !== 1'b0) begin failures++; $display("FAIL dead_direct_width got=%0b exp=0", deadViolO); end
    set_b(0, 1); wait_n(6);
  endtask

  task automatic test_rotation();
    int pv0;
    int s;
    pv0 = pv_count;
    enI = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s = i % 6;
      go_step(s);
      checks++; if (stepValidO !== 1'b1) begin failures++; $display("FAIL rot_valid%0d got=%0b exp=1", i, stepValidO); end
      checks++; if (stepO !== 3'(s)) begin failures++; $display("FAIL rot_step%0d got=%0d exp=%0d", i, stepO, s); end
      if (i > 0) begin
        checks++; if (dirO !== 1'b1) begin failures++; $display("FAIL rot_dir%0d got=%0b exp=1", i, dirO); end
      end
      if (i == 6) begin
        checks++; if (periodValidO !== 1'b1) begin failures++; $display("FAIL rot_pvalid got=%0b exp=1", periodValidO); end
        checks++; if (periodO !== 12'd600) begin failures++; $display("FAIL rot_period got=%0d exp=600", periodO); end
      end
      tick();
      checks++; if (stepValidO !== 1'b0) begin failures++; $display("FAIL rot_valid_width%0d got=%0b exp=0", i, stepValidO); end
      wait_n(97);
    end
    checks++; if (pv_count - pv0 !== 1) begin failures++; $display("FAIL rot_pv_count got=%0d exp=1", pv_count - pv0); end
  endtask

  task automatic test_direction();
    go_step(3);
    checks++; if ({seqErrO, dirO, stepO} !== 5'b11_011) begin failures++; $display("FAIL dir_jump03 got=%0b exp=11011", {seqErrO, dirO, stepO}); end
    wait_n(8);
    go_step(2);
    checks++; if ({seqErrO, dirO, stepO} !== 5'b00_010) begin failures++; $display("FAIL dir_reverse got=%0b exp=00010", {seqErrO, dirO, stepO}); end
    wait_n(8);
    go_step(5);
    checks++; if ({seqErrO, dirO, stepO} !== 5'b10_101) begin failures++; $display("FAIL dir_jump25 got=%0b exp=10101", {seqErrO, dirO, stepO}); end
    tick();
    checks++; if (seqErrO !== 1'b0) begin failures++; $display("FAIL dir_seq_width got=%0b exp=0", seqErrO); end
    wait_n(7);
  endtask

  task automatic test_stall();
    go_step(0);
    checks++; if (periodValidO !== 1'b1) begin failures++; $display("FAIL stall_entry_pv got=%0b exp=1", periodValidO); end
    wait_n(100);
    checks++; if (stallO !== 1'b0) begin failures++; $display("FAIL stall_early got=%0b exp=0", stallO); end
    wait_n(4100);
    checks++; if (stallO !== 1'b1) begin failures++; $display("FAIL stall_set got=%0b exp=1", stallO); end
    go_step(1);
    wait_n(3);
    go_step(0);
    checks++; if (periodO !== 12'd4095) begin failures++; $display("FAIL stall_period got=%0d exp=4095", periodO); end
    checks++; if (periodValidO !== 1'b1) begin failures++; $display("FAIL stall_pv got=%0b exp=1", periodValidO); end
    checks++; if (stallO !== 1'b0) begin failures++; $display("FAIL stall_clear got=%0b exp=0", stallO); end
    wait_n(8);
  endtask

  task automatic test_reset_mid();
    int pv0;
    go_step(1); wait_n(8);
    go_step(2); wait_n(8);
    nRstI = 1'b0;
    tick();
    nRstI = 1'b1;
    checks++; if (stepO !== 3'd7) begin failures++; $display("FAIL mid_rst_step got=%0d exp=7", stepO); end
    checks++; if (periodO !== 12'd0) begin failures++; $display("FAIL mid_rst_period got=%0d exp=0", periodO); end
    wait_n(2);
    checks++; if ({stepValidO, stepO} !== 4'b1010) begin failures++; $display("FAIL mid_rst_resume got=%0b exp=1010", {stepValidO, stepO}); end
    wait_n(8);
    pv0 = pv_count;
    for (int s = 3; s < 6; s++) begin go_step(s); wait_n(8); end
    go_step(0);
    checks++; if ({periodValidO, stepO} !== 4'b0000) begin failures++; $display("FAIL mid_first0 got=%0b exp=0000", {periodValidO, stepO}); end
    wait_n(8);
    for (int s = 1; s < 6; s++) begin go_step(s); wait_n(8); end
    go_step(0);
    checks++; if (periodO !== 12'd60) begin failures++; $display("FAIL mid_period got=%0d exp=60", periodO); end
    checks++; if (pv_count - pv0 !== 0) begin failures++; $display("FAIL mid_pv_before got=%0d exp=0", pv_count - pv0); end
    tick();
    checks++; if (pv_count - pv0 !== 1) begin failures++; $display("FAIL mid_pv_count got=%0d exp=1", pv_count - pv0); end
    wait_n(6);
  endtask

  task automatic test_enable();
    enI = 1'b0;
    tick();
    checks++; if ({stepO, dirO, stallO} !== 5'b11100) begin failures++; $display("FAIL en_off got=%0b exp=11100", {stepO, dirO, stallO}); end
    go_step(1);
    checks++; if ({stepValidO, stepO} !== 4'b0111) begin failures++; $display("FAIL en_off_step got=%0b exp=0111", {stepValidO, stepO}); end
  endtask

  initial begin
    test_reset();
    test_fault();
    test_deadtime();
    test_rotation();
    test_direction();
    test_stall();
    test_reset_mid();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
